// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: one shared read port with a single burst in flight.
// A captured AR is replayed on the master side; R beats are steered back to the owner.
module axi_rd_arbiter #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   s0_ar_id,
    input  logic [ADDR_WIDTH-1:0] s0_ar_addr,
    input  logic [7:0]            s0_ar_len,
    input  logic [2:0]            s0_ar_size,
    input  logic [1:0]            s0_ar_burst,
    input  logic                  s0_ar_lock,
    input  logic [3:0]            s0_ar_cache,
    input  logic [2:0]            s0_ar_prot,
    input  logic [3:0]            s0_ar_qos,
    input  logic [3:0]            s0_ar_region,
    input  logic [USER_WIDTH-1:0] s0_ar_user,
    input  logic                  s0_ar_valid,
    output logic                  s0_ar_ready,
    output logic [ID_WIDTH-1:0]   s0_r_id,
    output logic [DATA_WIDTH-1:0] s0_r_data,
    output logic [1:0]            s0_r_resp,
    output logic                  s0_r_last,
    output logic [USER_WIDTH-1:0] s0_r_user,
    output logic                  s0_r_valid,
    input  logic                  s0_r_ready,

    input  logic [ID_WIDTH-1:0]   s1_ar_id,
    input  logic [ADDR_WIDTH-1:0] s1_ar_addr,
    input  logic [7:0]            s1_ar_len,
    input  logic [2:0]            s1_ar_size,
    input  logic [1:0]            s1_ar_burst,
    input  logic                  s1_ar_lock,
    input  logic [3:0]            s1_ar_cache,
    input  logic [2:0]            s1_ar_prot,
    input  logic [3:0]            s1_ar_qos,
    input  logic [3:0]            s1_ar_region,
    input  logic [USER_WIDTH-1:0] s1_ar_user,
    input  logic                  s1_ar_valid,
    output logic                  s1_ar_ready,
    output logic [ID_WIDTH-1:0]   s1_r_id,
    output logic [DATA_WIDTH-1:0] s1_r_data,
    output logic [1:0]            s1_r_resp,
    output logic                  s1_r_last,
    output logic [USER_WIDTH-1:0] s1_r_user,
    output logic                  s1_r_valid,
    input  logic                  s1_r_ready,

    output logic [ID_WIDTH-1:0]   m_ar_id,
    output logic [ADDR_WIDTH-1:0] m_ar_addr,
    output logic [7:0]            m_ar_len,
    output logic [2:0]            m_ar_size,
    output logic [1:0]            m_ar_burst,
    output logic                  m_ar_lock,
    output logic [3:0]            m_ar_cache,
    output logic [2:0]            m_ar_prot,
    output logic [3:0]            m_ar_qos,
    output logic [3:0]            m_ar_region,
    output logic [USER_WIDTH-1:0] m_ar_user,
    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    input  logic [ID_WIDTH-1:0]   m_r_id,
    input  logic [DATA_WIDTH-1:0] m_r_data,
    input  logic [1:0]            m_r_resp,
    input  logic                  m_r_last,
    input  logic [USER_WIDTH-1:0] m_r_user,
    input  logic                  m_r_valid,
    output logic                  m_r_ready
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   prio_q, prio_d;
    logic   rst_q;

    logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic                  ar_lock_q, ar_lock_d;
    logic [3:0]            ar_cache_q, ar_cache_d;
    logic [2:0]            ar_prot_q, ar_prot_d;
    logic [3:0]            ar_qos_q, ar_qos_d;
    logic [3:0]            ar_region_q, ar_region_d;
    logic [USER_WIDTH-1:0] ar_user_q, ar_user_d;

    logic blk;
    logic gnt_valid;
    logic gnt_sel;
    logic in_data;

    // Outputs stay quiet while reset is applied and for one cycle after it.
    assign blk = rst | rst_q;

    always_comb begin
        gnt_valid = (s0_ar_valid | s1_ar_valid) & (state_q == StIdle) & ~blk;
        if (s0_ar_valid && s1_ar_valid) begin
            gnt_sel = prio_q;
        end else begin
            gnt_sel = s1_ar_valid;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        ar_burst_d  = ar_burst_q;
        ar_lock_d   = ar_lock_q;
        ar_cache_d  = ar_cache_q;
        ar_prot_d   = ar_prot_q;
        ar_qos_d    = ar_qos_q;
        ar_region_d = ar_region_q;
        ar_user_d   = ar_user_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    state_d = StAddr;
                    grant_d = gnt_sel;
                    prio_d  = ~gnt_sel;
                    if (gnt_sel) begin
                        ar_id_d     = s1_ar_id;
                        ar_addr_d   = s1_ar_addr;
                        ar_len_d    = s1_ar_len;
                        ar_size_d   = s1_ar_size;
                        ar_burst_d  = s1_ar_burst;
                        ar_lock_d   = s1_ar_lock;
                        ar_cache_d  = s1_ar_cache;
                        ar_prot_d   = s1_ar_prot;
                        ar_qos_d    = s1_ar_qos;
                        ar_region_d = s1_ar_region;
                        ar_user_d   = s1_ar_user;
                    end else begin
                        ar_id_d     = s0_ar_id;
                        ar_addr_d   = s0_ar_addr;
                        ar_len_d    = s0_ar_len;
                        ar_size_d   = s0_ar_size;
                        ar_burst_d  = s0_ar_burst;
                        ar_lock_d   = s0_ar_lock;
                        ar_cache_d  = s0_ar_cache;
                        ar_prot_d   = s0_ar_prot;
                        ar_qos_d    = s0_ar_qos;
                        ar_region_d = s0_ar_region;
                        ar_user_d   = s0_ar_user;
                    end
                end
            end
            StAddr: begin
                if (m_ar_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (m_r_valid && m_r_ready && m_r_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s0_ar_ready = gnt_valid & ~gnt_sel;
        s1_ar_ready = gnt_valid & gnt_sel;
        m_ar_valid  = (state_q == StAddr) & ~blk;
        in_data     = (state_q == StData) & ~blk;
        m_r_ready   = in_data & (grant_q ? s1_r_ready : s0_r_ready);
        s0_r_valid  = in_data & ~grant_q & m_r_valid;
        s1_r_valid  = in_data & grant_q & m_r_valid;
    end

    // Payload goes to both requesters; only the owner sees valid.
    assign s0_r_id   = m_r_id;
    assign s0_r_data = m_r_data;
    assign s0_r_resp = m_r_resp;
    assign s0_r_last = m_r_last;
    assign s0_r_user = m_r_user;
    assign s1_r_id   = m_r_id;
    assign s1_r_data = m_r_data;
    assign s1_r_resp = m_r_resp;
    assign s1_r_last = m_r_last;
    assign s1_r_user = m_r_user;

    assign m_ar_id     = ar_id_q;
    assign m_ar_addr   = ar_addr_q;
    assign m_ar_len    = ar_len_q;
    assign m_ar_size   = ar_size_q;
    assign m_ar_burst  = ar_burst_q;
    assign m_ar_lock   = ar_lock_q;
    assign m_ar_cache  = ar_cache_q;
    assign m_ar_prot   = ar_prot_q;
    assign m_ar_qos    = ar_qos_q;
    assign m_ar_region = ar_region_q;
    assign m_ar_user   = ar_user_q;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            ar_id_q     <= '0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            ar_size_q   <= '0;
            ar_burst_q  <= '0;
            ar_lock_q   <= 1'b0;
            ar_cache_q  <= '0;
            ar_prot_q   <= '0;
            ar_qos_q    <= '0;
            ar_region_q <= '0;
            ar_user_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            ar_id_q     <= ar_id_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            ar_size_q   <= ar_size_d;
            ar_burst_q  <= ar_burst_d;
            ar_lock_q   <= ar_lock_d;
            ar_cache_q  <= ar_cache_d;
            ar_prot_q   <= ar_prot_d;
            ar_qos_q    <= ar_qos_d;
            ar_region_q <= ar_region_d;
            ar_user_q   <= ar_user_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: transaction-level model checked every cycle,
// plus hand-computed expectations on grant order, beat counts and latencies.
module tb_axi_rd_arbiter;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [3:0] s0_ar_id, s1_ar_id, m_ar_id, s0_r_id, s1_r_id, m_r_id;
    logic [63:0] s0_ar_addr, s1_ar_addr, m_ar_addr, s0_r_data, s1_r_data, m_r_data;
    logic [7:0] s0_ar_len, s1_ar_len, m_ar_len;
    logic [2:0] s0_ar_size, s1_ar_size, m_ar_size, s0_ar_prot, s1_ar_prot, m_ar_prot;
    logic [1:0] s0_ar_burst, s1_ar_burst, m_ar_burst, s0_r_resp, s1_r_resp, m_r_resp;
    logic s0_ar_lock, s1_ar_lock, m_ar_lock;
    logic [3:0] s0_ar_cache, s1_ar_cache, m_ar_cache, s0_ar_qos, s1_ar_qos, m_ar_qos;
    logic [3:0] s0_ar_region, s1_ar_region, m_ar_region;
    logic [0:0] s0_ar_user, s1_ar_user, m_ar_user, s0_r_user, s1_r_user, m_r_user;
    logic s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready, m_ar_valid, m_ar_ready;
    logic s0_r_last, s1_r_last, m_r_last;
    logic s0_r_valid, s1_r_valid, m_r_valid;
    logic s0_r_ready, s1_r_ready = 1'b1, m_r_ready;

    axi_rd_arbiter #(.ID_WIDTH(4), .ADDR_WIDTH(64), .DATA_WIDTH(64), .USER_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .s0_ar_id(s0_ar_id), .s0_ar_addr(s0_ar_addr), .s0_ar_len(s0_ar_len),
        .s0_ar_size(s0_ar_size), .s0_ar_burst(s0_ar_burst), .s0_ar_lock(s0_ar_lock),
        .s0_ar_cache(s0_ar_cache), .s0_ar_prot(s0_ar_prot), .s0_ar_qos(s0_ar_qos),
        .s0_ar_region(s0_ar_region), .s0_ar_user(s0_ar_user), .s0_ar_valid(s0_ar_valid),
        .s0_ar_ready(s0_ar_ready), .s0_r_id(s0_r_id), .s0_r_data(s0_r_data),
        .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last), .s0_r_user(s0_r_user),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
        .s1_ar_id(s1_ar_id), .s1_ar_addr(s1_ar_addr), .s1_ar_len(s1_ar_len),
        .s1_ar_size(s1_ar_size), .s1_ar_burst(s1_ar_burst), .s1_ar_lock(s1_ar_lock),
        .s1_ar_cache(s1_ar_cache), .s1_ar_prot(s1_ar_prot), .s1_ar_qos(s1_ar_qos),
        .s1_ar_region(s1_ar_region), .s1_ar_user(s1_ar_user), .s1_ar_valid(s1_ar_valid),
        .s1_ar_ready(s1_ar_ready), .s1_r_id(s1_r_id), .s1_r_data(s1_r_data),
        .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last), .s1_r_user(s1_r_user),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
        .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock),
        .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos),
        .m_ar_region(m_ar_region), .m_ar_user(m_ar_user), .m_ar_valid(m_ar_valid),
        .m_ar_ready(m_ar_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_user(m_r_user),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Stimulus controls and reactive requester/slave state.
    ar_t rq0[16], rq1[16];
    int n0 = 0, n1 = 0, h0 = 0, h1 = 0;
    bit rst_req = 1'b1, flash0 = 1'b0, stray = 1'b0, tog1 = 1'b0;
    int stall_cfg = 0, stall_cnt = 0;
    bit sl_busy = 1'b0;
    int sl_left = 0, sl_beat = 0;
    logic [3:0] sl_id = '0;
    logic [0:0] sl_user = '0;
    bit hs0, hs1, hs_mar, hs_r, was_rst, mv;
    ar_t mar_s;
    int obs0 = 0, obs1 = 0, mav_cnt = 0;

    // Behavioural model: who owns the port, whether its address went out, fairness pointer.
    bit md_valid = 1'b0, md_busy, md_sent, md_owner, md_prio, md_after;
    ar_t md_cap;
    int glog[$];
    int gcyc[$];
    int mbeats[2] = '{0, 0};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic ar_t mk(input logic [3:0] id, input logic [63:0] addr,
                               input logic [7:0] len);
        ar_t r;
        r = '0;
        r.id = id;
        r.addr = addr;
        r.len = len;
        r.size = 3'd3;
        r.burst = 2'b01;
        r.cache = 4'h3;
        r.prot = id[2:0];
        r.qos = id;
        r.region = 4'h1;
        r.user = id[0];
        return r;
    endfunction

    function automatic ar_t cur_mar();
        return {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock, m_ar_cache,
                m_ar_prot, m_ar_qos, m_ar_region, m_ar_user};
    endfunction

    task automatic drive();
        ar_t c0, c1, junk;
        junk = '1;
        rst = rst_req;
        if (hs0) h0++;
        if (hs1) h1++;
        if (was_rst) begin
            sl_busy = 1'b0;
            stall_cnt = 0;
        end else begin
            if (hs_r) begin
                if (sl_left == 0) sl_busy = 1'b0;
                else begin
                    sl_left--;
                    sl_beat++;
                end
            end
            if (hs_mar) begin
                sl_busy = 1'b1;
                sl_left = int'(mar_s.len);
                sl_beat = 0;
                sl_id = mar_s.id;
                sl_user = mar_s.user;
                stall_cnt = 0;
            end else if (mv) begin
                stall_cnt++;
            end
        end
        c0 = (h0 < n0) ? rq0[h0] : (flash0 ? junk : '0);
        c1 = (h1 < n1) ? rq1[h1] : '0;
        s0_ar_valid = (h0 < n0) || flash0;
        s1_ar_valid = (h1 < n1);
        {s0_ar_id, s0_ar_addr, s0_ar_len, s0_ar_size, s0_ar_burst, s0_ar_lock, s0_ar_cache,
         s0_ar_prot, s0_ar_qos, s0_ar_region, s0_ar_user} = c0;
        {s1_ar_id, s1_ar_addr, s1_ar_len, s1_ar_size, s1_ar_burst, s1_ar_lock, s1_ar_cache,
         s1_ar_prot, s1_ar_qos, s1_ar_region, s1_ar_user} = c1;
        m_ar_ready = (stall_cnt >= stall_cfg);
        if (sl_busy) begin
            m_r_valid = 1'b1;
            m_r_id = sl_id;
            m_r_data = {32'hDA7A_0000, 12'h0, sl_id, 16'(sl_beat)};
            m_r_resp = 2'b00;
            m_r_last = (sl_left == 0);
            m_r_user = sl_user;
        end else begin
            m_r_valid = stray;
            m_r_id = 4'hE;
            m_r_data = 64'hBAD0_BAD0_BAD0_BAD0;
            m_r_resp = 2'b11;
            m_r_last = 1'b1;
            m_r_user = 1'b1;
        end
        s0_r_ready = 1'b1;
        s1_r_ready = tog1 ? ~s1_r_ready : 1'b1;
    endtask

    task automatic check_cycle();
        ar_t c0, c1;
        bit any, win, data;
        bit e_ar0 = 0, e_ar1 = 0, e_mav = 0, e_mrr = 0, e_rv0 = 0, e_rv1 = 0;
        c0 = {s0_ar_id, s0_ar_addr, s0_ar_len, s0_ar_size, s0_ar_burst, s0_ar_lock,
              s0_ar_cache, s0_ar_prot, s0_ar_qos, s0_ar_region, s0_ar_user};
        c1 = {s1_ar_id, s1_ar_addr, s1_ar_len, s1_ar_size, s1_ar_burst, s1_ar_lock,
              s1_ar_cache, s1_ar_prot, s1_ar_qos, s1_ar_region, s1_ar_user};
        any = 1'b0;
        win = 1'b0;
        data = 1'b0;
        if (!rst) begin
            if (!md_valid) return;
            any = s0_ar_valid || s1_ar_valid;
            win = (s0_ar_valid && s1_ar_valid) ? md_prio : s1_ar_valid;
            e_ar0 = !md_busy && !md_after && any && !win;
            e_ar1 = !md_busy && !md_after && any && win;
            e_mav = md_busy && !md_sent;
            data = md_busy && md_sent;
            e_mrr = data && (md_owner ? s1_r_ready : s0_r_ready);
            e_rv0 = data && !md_owner && m_r_valid;
            e_rv1 = data && md_owner && m_r_valid;
        end
        chk("s0_ar_ready", 128'(s0_ar_ready), 128'(e_ar0));
        chk("s1_ar_ready", 128'(s1_ar_ready), 128'(e_ar1));
        chk("m_ar_valid", 128'(m_ar_valid), 128'(e_mav));
        chk("m_r_ready", 128'(m_r_ready), 128'(e_mrr));
        chk("s0_r_valid", 128'(s0_r_valid), 128'(e_rv0));
        chk("s1_r_valid", 128'(s1_r_valid), 128'(e_rv1));
        if (e_mav) chk("m_ar_fields", 128'(cur_mar()), 128'(md_cap));
        if (e_rv0)
            chk("s0_r_fields", 128'({s0_r_id, s0_r_data, s0_r_resp, s0_r_last, s0_r_user}),
                128'({m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user}));
        if (e_rv1)
            chk("s1_r_fields", 128'({s1_r_id, s1_r_data, s1_r_resp, s1_r_last, s1_r_user}),
                128'({m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user}));
        if (rst) begin
            md_valid = 1'b1;
            md_busy = 1'b0;
            md_sent = 1'b0;
            md_owner = 1'b0;
            md_prio = 1'b0;
            md_cap = '0;
            md_after = 1'b1;
        end else begin
            if (e_ar0 || e_ar1) begin
                md_busy = 1'b1;
                md_sent = 1'b0;
                md_owner = win;
                md_prio = !win;
                md_cap = win ? c1 : c0;
                glog.push_back(int'(win));
                gcyc.push_back(cyc);
            end else if (e_mav && m_ar_ready) begin
                md_sent = 1'b1;
            end else if (data && m_r_valid && e_mrr) begin
                mbeats[md_owner]++;
                if (m_r_last) md_busy = 1'b0;
            end
            md_after = 1'b0;
        end
    endtask

    task automatic sample();
        hs0 = s0_ar_valid && s0_ar_ready;
        hs1 = s1_ar_valid && s1_ar_ready;
        was_rst = rst;
        mv = m_ar_valid;
        hs_mar = m_ar_valid && m_ar_ready;
        hs_r = m_r_valid && m_r_ready;
        mar_s = cur_mar();
        if (s0_r_valid && s0_r_ready) obs0++;
        if (s1_r_valid && s1_r_ready) obs1++;
        if (m_ar_valid) mav_cnt++;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            check_cycle();
            sample();
            cyc++;
        end
    endtask

    initial begin
        int b0, b1, g, m;
        tick(3);
        rst_req = 1'b0;
        tick(1);
        chk("reset_mar_cleared", 128'(cur_mar()), 128'(0));
        chk("reset_no_grants", 128'(glog.size()), 128'(0));

        // Single requester, len=3.
        rq0[n0] = mk(4'd2, 64'h1000, 8'd3);
        n0++;
        for (int i = 0; i < 60 && obs0 < 4; i++) tick();
        tick(2);
        chk("single_s0_beats", 128'(obs0), 128'(4));
        chk("single_model_beats", 128'(mbeats[0]), 128'(4));
        chk("single_s1_beats", 128'(obs1), 128'(0));
        chk("single_grant0", 128'(glog[0]), 128'(0));
        // AR accepted at the first grant cycle; the master sees it one cycle later.
        chk("single_mar_cycles", 128'(mav_cnt), 128'(1));

        // Contention straight after reset.
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        tick(1);
        b0 = obs0;
        b1 = obs1;
        g = glog.size();
        rq0[n0] = mk(4'd3, 64'h2000, 8'd1);
        n0++;
        rq1[n1] = mk(4'd5, 64'h3000, 8'd1);
        n1++;
        for (int i = 0; i < 60 && (obs0 < b0 + 2 || obs1 < b1 + 2); i++) tick();
        tick(2);
        chk("contend_grants", 128'(glog.size() - g), 128'(2));
        chk("contend_first", 128'(glog[g]), 128'(0));
        chk("contend_second", 128'(glog[g + 1]), 128'(1));
        chk("contend_prio_back0", 128'(md_prio), 128'(0));
        chk("contend_beats", 128'((obs0 - b0) * 10 + (obs1 - b1)), 128'(22));

        // Back-pressure on AR plus toggling s1_r_ready; a stray s0 valid while busy.
        b1 = obs1;
        g = glog.size();
        m = mav_cnt;
        stall_cfg = 5;
        tog1 = 1'b1;
        rq1[n1] = mk(4'd6, 64'h4000, 8'd3);
        n1++;
        for (int i = 0; i < 10 && glog.size() == g; i++) tick();
        tick(1);
        flash0 = 1'b1;
        tick(3);
        flash0 = 1'b0;
        for (int i = 0; i < 80 && obs1 < b1 + 4; i++) tick();
        tick(3);
        stall_cfg = 0;
        tog1 = 1'b0;
        tick(1);
        chk("bp_s1_beats", 128'(obs1 - b1), 128'(4));
        chk("bp_mar_valid_cycles", 128'(mav_cnt - m), 128'(6));
        chk("bp_single_grant", 128'(glog.size() - g), 128'(1));
        chk("bp_owner", 128'(glog[g]), 128'(1));

        // Fairness: both continuously valid, len=0.
        g = glog.size();
        for (int k = 0; k < 3; k++) begin
            rq0[n0] = mk(4'(8 + k), 64'h5000 + 64'(k * 64), 8'd0);
            n0++;
            rq1[n1] = mk(4'(11 + k), 64'h6000 + 64'(k * 64), 8'd0);
            n1++;
        end
        for (int i = 0; i < 100 && (h0 < n0 || h1 < n1 || sl_busy); i++) tick();
        tick(3);
        chk("fair_grants", 128'(glog.size() - g), 128'(6));
        for (int k = 0; k < 6; k++) chk("fair_order", 128'(glog[g + k]), 128'(k % 2));
        for (int k = 0; k < 5; k++)
            chk("fair_gap", 128'(gcyc[g + k + 1] - gcyc[g + k]), 128'(3));

        // Reset after 2 of 4 beats.
        b0 = obs0;
        rq0[n0] = mk(4'd7, 64'h7000, 8'd3);
        n0++;
        for (int i = 0; i < 40 && obs0 < b0 + 2; i++) tick();
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        tick(1);
        chk("rstmid_mar_cleared", 128'(cur_mar()), 128'(0));
        b1 = obs1;
        g = glog.size();
        rq1[n1] = mk(4'd9, 64'h8000, 8'd0);
        n1++;
        for (int i = 0; i < 40 && obs1 < b1 + 1; i++) tick();
        tick(4);
        chk("rstmid_s0_beats", 128'(obs0 - b0), 128'(2));
        chk("rstmid_s1_beats", 128'(obs1 - b1), 128'(1));
        chk("rstmid_grant_s1", 128'(glog[g]), 128'(1));

        // Stray beat while idle.
        b0 = obs0;
        b1 = obs1;
        stray = 1'b1;
        tick(4);
        stray = 1'b0;
        tick(1);
        chk("stray_no_beats", 128'((obs0 - b0) + (obs1 - b1)), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
Parameters:
REQ-001 ID_WIDTH, default 4, AR/R id width, passed through unchanged.
REQ-002 ADDR_WIDTH, default 64, AR address width.
REQ-003 DATA_WIDTH, default 64, R data width.
REQ-004 USER_WIDTH, default 1, AR/R user width; must be >0.

Ports (N = 0,1; one requester port per N):
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 sN_ar_id/addr/len/size/burst/lock/cache/prot/qos/region/user  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  requester N read address fields.
REQ-008 sN_ar_valid  in  1 / sN_ar_ready  out  1  requester N AR handshake.
REQ-009 sN_r_id/data/resp/last/user  out  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH  requester N read data fields.
REQ-010 sN_r_valid  out  1 / sN_r_ready  in  1  requester N R handshake.
REQ-011 m_ar_* (same fields and widths as REQ-007)  out  shared master-side AR fields; m_ar_valid out 1, m_ar_ready in 1.
REQ-012 m_r_id/data/resp/last/user  in  shared R fields; m_r_valid in 1, m_r_ready out 1.

Function
REQ-013 The block SHALL share one AXI read port between two requesters, one burst outstanding at a time.
REQ-014 FSM states SHALL be IDLE, ADDR, DATA; reset state IDLE.
REQ-015 IDLE: if any sN_ar_valid, assert sN_ar_ready for the granted N only (combinational), capture its AR fields into a register that cycle, record grant, go ADDR.
REQ-016 Grant rule: one valid -> that requester; both valid -> requester indicated by priority pointer prio.
REQ-017 prio SHALL reset to 0 and, on every grant, be set to the requester not granted.
REQ-018 ADDR: m_ar_valid=1 with registered fields; hold fields stable until m_ar_ready; on handshake go DATA.
REQ-019 DATA: sG_r_* = m_r_* and sG_r_valid = m_r_valid for granted G; m_r_ready = sG_r_ready; other requester r_valid=0.
REQ-020 DATA: on beat handshake with m_r_last=1, go IDLE; new grant no earlier than the following cycle.
REQ-021 sN_ar_ready SHALL be 0 in ADDR and DATA; m_ar_valid SHALL be 0 in IDLE and DATA; m_r_ready SHALL be 0 outside DATA.
REQ-022 R beats arriving outside DATA SHALL be neither accepted nor forwarded.
REQ-023 All fields (id, user, resp) SHALL pass unmodified; no id remapping, no arithmetic on len.
REQ-024 Minimum latency: sN_ar handshake cycle T -> m_ar_valid at T+1; grant-to-grant for len=0 with zero-wait slave: 3 cycles.
REQ-025 A requester dropping sN_ar_valid while not granted SHALL have no effect.

Reset
REQ-026 rst=1 at any clock edge SHALL force IDLE, prio=0, captured AR register cleared, grant cleared, including mid-ADDR or mid-DATA.
REQ-027 During and the cycle after reset: all sN_ar_ready, sN_r_valid, m_ar_valid, m_r_ready = 0; in-flight burst abandoned, no beats forwarded.

Verification
REQ-028 Single requester: s0 AR addr=0x1000 len=3 id=2, slave ready -> m_ar addr=0x1000 len=3 id=2 one cycle after accept; 4 beats to s0, s1_r_valid=0 throughout.
REQ-029 Contention after reset: s0 and s1 assert AR same cycle -> s0 granted first, s1 granted after s0 rlast, then prio=0.
REQ-030 Back-pressure: m_ar_ready low 5 cycles -> m_ar fields stable, sN_ar_ready=0; s1_r_ready toggling -> m_r_ready mirrors, no beat lost or duplicated.
REQ-031 Fairness: both requesters continuously valid, 6 bursts len=0 -> grant order 0,1,0,1,0,1.
REQ-032 Reset mid-DATA: rst pulsed after 2 of 4 beats -> outputs 0, state IDLE, next request from s1 granted (prio=0 but s0 idle) with clean AR.
REQ-033 Stray beat: m_r_valid=1 in IDLE -> m_r_ready=0, sN_r_valid=0.
